// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file address range through one read port and
// streams (address, data) pairs over a valid/ready handshake. The regfile write
// port is snooped so a streamed word always matches the register contents at
// the moment the consumer takes it.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int FIRST  = 0,
  parameter int LAST   = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              regw,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [DATA_W-1:0] dout_n;
  logic [ADDR_W-1:0] dout_addr_n;

  logic read_hit;
  logic hold_hit;
  logic accept;

  // Snoop comparators: register 0 is hard-wired to zero, so writes to it never
  // change what the regfile returns and must not be forwarded.
  always_comb begin
    read_hit = regw && (wr == rd_addr)   && (wr != '0);
    hold_hit = regw && (wr == dout_addr) && (wr != '0);
    accept   = (state == HOLD) && dout_ready;
  end

  // Next-state and next-datapath decode for the dump walk.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_n     = state;
    rd_addr_n   = rd_addr;
    dout_n      = dout;
    dout_addr_n = dout_addr;

    unique case (state)
      IDLE: begin
        rd_addr_n = FIRST_A;
        if (start) state_n = READ;
      end

      READ: begin
        // The regfile updates on this same edge, so rd_data is stale on a hit.
        dout_n      = read_hit ? wdata : rd_data;
        dout_addr_n = rd_addr;
        state_n     = HOLD;
      end

      HOLD: begin
        if (accept) begin
          // A write landing on the accept edge is not forwarded: the consumer
          // takes the old word and the new value shows up in a later dump.
          if (rd_addr == LAST_A) begin
            state_n = DONE;
          end else begin
            rd_addr_n = rd_addr + ADDR_W'(1);
            state_n   = READ;
          end
        end else if (hold_hit) begin
          dout_n = wdata;
        end
      end

      DONE: begin
        rd_addr_n = FIRST_A;
        state_n   = IDLE;
      end

      default: begin
        state_n   = IDLE;
        rd_addr_n = FIRST_A;
      end
    endcase
  end

  // State register; asynchronous reset returns the engine to IDLE mid-dump.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath registers: read address and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every datapath register is reset so the outputs are defined the
    // instant rst rises, not only after the first clock.
    if (rst) begin
      rd_addr   <= FIRST_A;
      dout      <= '0;
      dout_addr <= '0;
    end else begin
      rd_addr   <= rd_addr_n;
      dout      <= dout_n;
      dout_addr <= dout_addr_n;
    end
  end

  // Status outputs are pure state decodes, so they also clear asynchronously.
  always_comb begin
    dout_valid = (state == HOLD);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

endmodule
